// File: rtl/i2c_temp_slave.sv
`timescale 1ns/1ps
// Purpose: oversampled I2C slave for an LM75-class sensor; NUM_REGS pointer-addressed registers, reg 0 = live temperature.
// Latency: SCL/SDA pass a 2-flop synchroniser plus an edge flop, so SDA drive changes about 3 i_clk after the SCL fall at the pad.
// Backpressure: none; bytes are always ACKed once addressed. The master throttles by stretching SCL. A NACK ends a read.
//
// Ports:
//   i_clk          system clock, at least 8x SCL
//   i_rst_n        asynchronous active-low reset (releases SDA immediately)
//   i_scl, i_sda   asynchronous bus pad inputs
//   o_sda_oe       1 = pull SDA low (open drain)
//   i_addr_pins    strap replacing the address LSBs
//   i_temp         new temperature sample, 8*REG_BYTES bits
//   i_temp_valid   one-cycle strobe loading i_temp into reg 0 (unless shutdown)
//   o_os_n         over-temperature output, only when I2C_SLV_ALERT_EN is defined
//
// Optional feature macro: I2C_SLV_ALERT_EN (adds o_os_n and the hysteresis comparator).
// Config register (reg 1) byte is the MSB lane: bit 0 = shutdown, bit 2 = OS polarity.
// NUM_REGS is expected to be a power of two, so every pointer value selects a register.
module i2c_temp_slave #(
  parameter logic [6:0]  ADDR_BASE = 7'h48,
  parameter int          REG_BYTES = 2,
  parameter int          NUM_REGS  = 4,
  parameter logic [15:0] THYST_RST = 16'h4B00,
  parameter logic [15:0] TOS_RST   = 16'h5000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_scl,
  input  logic                   i_sda,
  output logic                   o_sda_oe,
  input  logic [2:0]             i_addr_pins,
  input  logic [8*REG_BYTES-1:0] i_temp,
  input  logic                   i_temp_valid
`ifdef I2C_SLV_ALERT_EN
  ,
  output logic                   o_os_n
`endif
);

  localparam int REG_W = 8 * REG_BYTES;
  localparam int PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int BI_W  = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;
  // 16-bit reset constants are left-aligned into the register width
  localparam logic [31:0]      THYST32 = {THYST_RST, 16'h0000};
  localparam logic [31:0]      TOS32   = {TOS_RST, 16'h0000};
  localparam logic [REG_W-1:0] THYST_L = THYST32[31 -: REG_W];
  localparam logic [REG_W-1:0] TOS_L   = TOS32[31 -: REG_W];

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_scl_s, r_sda_s;
  logic               r_scl_d, r_sda_d;
  logic [3:0]         r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]         r_shift, w_shift_nxt;
  logic               r_rw, w_rw_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [BI_W-1:0]    r_byte_idx, w_byte_idx_nxt;
  logic [REG_W-1:0]   r_shadow, w_shadow_nxt;
  logic               r_sda_oe, w_sda_oe_nxt;
  logic               w_wr_en;
  logic [REG_W-1:0]   r_regs [NUM_REGS];

  logic               w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [REG_W-1:0]   w_cur_reg;
  logic               w_last_byte;
  logic               w_shutdown;
  logic [6:0]         w_dev_addr;

  assign w_scl       = r_scl_s[1];
  assign w_sda       = r_sda_s[1];
  assign w_scl_rise  = w_scl & ~r_scl_d;
  assign w_scl_fall  = ~w_scl & r_scl_d;
  assign w_start     = r_sda_d & ~w_sda & w_scl & r_scl_d;
  assign w_stop      = ~r_sda_d & w_sda & w_scl & r_scl_d;
  assign w_cur_reg   = r_regs[r_ptr];
  assign w_last_byte = (r_byte_idx == BI_W'(REG_BYTES - 1));
  assign w_shutdown  = r_regs[1][REG_W-8];
  assign w_dev_addr  = {ADDR_BASE[6:3], i_addr_pins};
  assign o_sda_oe    = r_sda_oe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_s    <= 2'b11;
      r_sda_s    <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_ptr      <= '0;
      r_byte_idx <= '0;
      r_shadow   <= '0;
      r_sda_oe   <= 1'b0;
    end else begin
      r_scl_s    <= {r_scl_s[0], i_scl};
      r_sda_s    <= {r_sda_s[0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rw       <= w_rw_nxt;
      r_ptr      <= w_ptr_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_shadow   <= w_shadow_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_rw_nxt       = r_rw;
    w_ptr_nxt      = r_ptr;
    w_byte_idx_nxt = r_byte_idx;
    w_shadow_nxt   = r_shadow;
    w_sda_oe_nxt   = r_sda_oe;
    w_wr_en        = 1'b0;
    if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = S_ADDR;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WR_DATA: begin
          if (w_scl_rise && r_bit_cnt != 4'd8) begin
            w_shift_nxt   = {r_shift[6:0], w_sda};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
          // ACK is driven from the SCL fall that ends bit 8
          if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_bit_cnt_nxt = '0;
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == w_dev_addr) begin
                w_state_nxt  = S_ADDR_ACK;
                w_rw_nxt     = r_shift[0];
                w_sda_oe_nxt = 1'b1;
              end else begin
                w_state_nxt  = S_WAIT_STOP;
              end
            end else if (r_state == S_PTR) begin
              w_ptr_nxt    = r_shift[PTR_W-1:0];
              w_state_nxt  = S_PTR_ACK;
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_wr_en      = 1'b1;
              w_state_nxt  = S_WR_ACK;
              w_sda_oe_nxt = 1'b1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (r_rw) begin
              w_shadow_nxt   = w_cur_reg;
              w_byte_idx_nxt = '0;
              w_sda_oe_nxt   = ~w_cur_reg[REG_W-1];
              w_state_nxt    = S_RD_DATA;
            end else begin
              w_sda_oe_nxt   = 1'b0;
              w_state_nxt    = S_PTR;
            end
          end
        end
        S_PTR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt   = 1'b0;
            w_byte_idx_nxt = '0;
            w_state_nxt    = S_WR_DATA;
          end
        end
        S_WR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt   = 1'b0;
            w_byte_idx_nxt = w_last_byte ? '0 : r_byte_idx + 1'b1;
            w_state_nxt    = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (w_scl_rise && r_bit_cnt != 4'd8)
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          // The shadow shifts left once per bit, so after a byte its MSB is the next byte's MSB
          if (w_scl_fall) begin
            w_shadow_nxt = r_shadow << 1;
            if (r_bit_cnt == 4'd8) begin
              w_bit_cnt_nxt = '0;
              w_sda_oe_nxt  = 1'b0;
              w_state_nxt   = S_RD_ACK;
            end else begin
              w_sda_oe_nxt  = ~r_shadow[REG_W-2];
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise)
            w_shift_nxt = {r_shift[6:0], w_sda};
          if (w_scl_fall) begin
            if (!r_shift[0]) begin
              w_state_nxt = S_RD_DATA;
              if (w_last_byte) begin
                w_shadow_nxt   = w_cur_reg;
                w_byte_idx_nxt = '0;
                w_sda_oe_nxt   = ~w_cur_reg[REG_W-1];
              end else begin
                w_byte_idx_nxt = r_byte_idx + 1'b1;
                w_sda_oe_nxt   = ~r_shadow[REG_W-1];
              end
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Register file: reg 0 only takes temperature samples; bus writes to it are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= (i == 2) ? THYST_L : (i == 3) ? TOS_L : '0;
    end else begin
      if (i_temp_valid && !w_shutdown)
        r_regs[0] <= i_temp;
      if (w_wr_en) begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (r_ptr == PTR_W'(i)) begin
            for (int b = 0; b < REG_BYTES; b++) begin
              if (r_byte_idx == BI_W'(REG_BYTES - 1 - b))
                r_regs[i][8*b +: 8] <= r_shift;
            end
          end
        end
      end
    end
  end

`ifdef I2C_SLV_ALERT_EN
  // Hysteresis: set above TOS (reg 3), clear below THYST (reg 2), hold in between
  logic r_alert;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_alert <= 1'b0;
    else if ($signed(r_regs[0]) > $signed(r_regs[3]))
      r_alert <= 1'b1;
    else if ($signed(r_regs[0]) < $signed(r_regs[2]))
      r_alert <= 1'b0;
  end
  assign o_os_n = r_regs[1][REG_W-6] ? r_alert : ~r_alert;
`endif

endmodule

// File: doc/i2c_temp_slave.md
Name: i2c_temp_slave

Overview:
- Synthesisable, clocked I2C slave for an LM75-class temperature sensor; next generation of the behavioural I2C slave model.
- Oversamples SCL/SDA on the system clock and serves NUM_REGS pointer-addressed registers, each REG_BYTES bytes wide.
- Register 0 holds the live temperature from an on-chip source. Sits between the board I2C bus pads and the sensor datapath.

Parameters:
- ADDR_BASE, 7'h48: slave address; bits [2:0] replaced by Addr_pins.
- REG_BYTES, 2: bytes per register (1..4); register width = 8*REG_BYTES.
- NUM_REGS, 4: number of registers; PTR_W = clog2(NUM_REGS).
- THYST_RST, 16'h4B00: reset value of reg 2 (75 C), left-aligned in register width.
- TOS_RST, 16'h5000: reset value of reg 3 (80 C), left-aligned in register width.

Ports:
- Clk, in, 1: system clock; must be at least 8x SCL.
- Rst, in, 1: asynchronous, active-low reset.
- Scl_in, in, 1: SCL pad input, asynchronous.
- Sda_in, in, 1: SDA pad input, asynchronous.
- Sda_oe, out, 1: 1 = pull SDA low (open drain); 0 = release.
- Addr_pins, in, 3: strap for the address LSBs.
- Temp_in, in, 8*REG_BYTES: new temperature sample.
- Temp_valid, in, 1: one-cycle strobe; load Temp_in into reg 0.

Behaviour:
- Sync and edge detect: 2-flop synchronisers on Scl_in and Sda_in. scl_rise/scl_fall are taken from the synchronised SCL.
- START: synced SDA falls while synced SCL = 1. STOP: synced SDA rises while SCL = 1.
- START from any state, including a repeated START, goes to ADDR: bit_cnt = 0, Sda_oe = 0.
- STOP from any state goes to IDLE with Sda_oe = 0.
- Sampling: SDA is sampled on scl_rise. Sda_oe changes only on scl_fall, so SDA is stable while SCL is high.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- ADDR: shift 8 bits, MSB first.
  - If byte[7:1] == {ADDR_BASE[6:3], Addr_pins}: go to ADDR_ACK and latch R_W = byte[0].
  - Otherwise go to WAIT_STOP; never drive SDA.
- ADDR_ACK: Sda_oe = 1 for exactly one SCL period, from scl_fall after bit 8 to the next scl_fall.
  - R_W = 0: go to PTR.
  - R_W = 1: load rd_shadow = reg[ptr], set byte_idx = 0, go to RD_DATA.
- PTR: 8 bits; ptr = byte[PTR_W-1:0], upper bits ignored; ACK, then WR_DATA.
- WR_DATA: each byte is written to byte lane (REG_BYTES-1-byte_idx) of reg[ptr], then ACKed.
  - byte_idx increments and wraps to 0 after REG_BYTES. ptr never auto-increments.
  - Writes to reg 0 are ACKed and discarded.
- RD_DATA: drive rd_shadow bytes MSB first; Sda_oe = ~bit.
  - RD_ACK releases SDA and samples the master's bit.
  - ACK (0): next byte; byte_idx wraps and re-shadows the same reg.
  - NACK (1): go to WAIT_STOP.
- Temperature update: Temp_valid loads reg 0 unless config bit 0 (shutdown) = 1.
  - Temp_valid has priority over nothing; reg 0 is never bus-written.
  - The shadow guarantees no tearing within a read.
- Reset values: Sda_oe = 0, state IDLE, ptr = 0, reg0 = 0, reg1 = 0, reg2 = THYST_RST, reg3 = TOS_RST, other regs = 0.
- Reset asserted mid-transfer releases SDA immediately (asynchronous).

Optional Feature:
- I2C_SLV_ALERT_EN defined:
  - Adds output Os_n, 1 bit, reset value 1.
  - Comparator with hysteresis: asserts (0) when signed reg0 > signed reg3; deasserts when reg0 < reg2.
  - Config bit 2 = 1 inverts polarity. Evaluated one Clk after any reg change.
- Not defined: no Os_n port and no comparator logic; the config bit 2 storage remains.

Test Plan:
- Write pointer: START, 0x90, 0x01, 0x60, STOP (Addr_pins = 0) -> three ACKs; reg1 = 0x60; Sda_oe = 0 after STOP.
- Read temperature: Temp_in = 0x1980 with Temp_valid, then START, 0x90, 0x00, repeated START, 0x91, read 2 bytes ACK/NACK -> bytes 0x19, 0x80; WAIT_STOP.
- Address mismatch: Addr_pins = 3'b001, master sends 0x90 -> no ACK (Sda_oe stays 0 for the whole transfer).
- Shutdown: reg1 = 0x01, Temp_valid with 0x2000 -> reg 0 read still returns the old 0x1980; reg0 write 0x1234 ACKed but ignored.
- Reset mid-read: assert Rst while Sda_oe = 1 during a data bit -> Sda_oe = 0 in the same cycle; reg2 = 0x4B00.
- Optional, with I2C_SLV_ALERT_EN: Temp 0x5100 -> Os_n = 0; then 0x4C00 -> Os_n stays 0; then 0x4A00 -> Os_n = 1.
